expr_tx: RTL
============

# expr_tx

Serial expression generator: the transmit end of the one-ASCII-character-per-cycle expression stream consumed by the expression checker. On `start`, it latches a packed request of decimal digits and operators. It then emits the well-formed infix string (digit, op, digit, …, digit) one byte per transfer over a valid/ready handshake, and pulses `done` after the last character. It serves as stimulus source and loopback partner for the checker, and as the front end for later expression-evaluation blocks.

## Interface
- `MAX_TERMS`, 4: maximum operand count; must be ≥ 2.
- `clk` input 1: clock; all state updates on the rising edge.
- `clr_n` input 1: reset, asynchronous, active-low.
- `start` input 1: request strobe; sampled only in IDLE.
- `num_terms` input $clog2(MAX_TERMS+1): operand count; legal range 1..MAX_TERMS.
- `digits` input 4*MAX_TERMS: term k is `digits[4k+3:4k]`, BCD 0..9.
- `ops` input MAX_TERMS-1: operator k sits between term k and term k+1; 0 = '+' (0x2B), 1 = '*' (0x2A).
- `busy` output 1: high while a request is in progress.
- `out_valid` output 1: `out_char` holds a character.
- `out_ready` input 1: sink accepts the character; a transfer occurs when valid and ready are both high at a rising edge.
- `out_char` output 8: ASCII character; 0x00 whenever `out_valid` = 0.
- `done` output 1: one-cycle pulse after the last transfer.
- `err` output 1: one-cycle pulse when a request is rejected.

## Operation
- States: IDLE, DIGIT, OP, DONE.
- IDLE:
  - On `start`, validate the request. It is illegal if `num_terms` = 0, `num_terms` > MAX_TERMS, or any used term (k < num_terms) is > 9. Unused terms and ops are don't-care.
  - Illegal request: pulse `err` next cycle; stay in IDLE; emit nothing.
  - Legal request: latch `num_terms`, `digits` and `ops`; clear the term index k; go to DIGIT.
- DIGIT: `out_valid` = 1, `out_char` = 0x30 + term k.
  - On transfer, go to OP if k < num_terms-1, else go to DONE.
  - No transfer: hold the state.
- OP: `out_valid` = 1, `out_char` = op k.
  - On transfer: k ← k+1, go to DIGIT.
- DONE: `done` = 1 for exactly one cycle, then return to IDLE.
- `busy` = 1 in DIGIT, OP and DONE.
- `start` while busy is ignored. Latched data is never altered mid-stream; input changes after the start cycle have no effect.
- `out_char` is stable while `out_valid` = 1 and `out_ready` = 0. No character is dropped or duplicated.
- Output length is always 2·num_terms − 1 characters. The stream is always accepted by the checker.

## Timing
- Reset (`clr_n` low, asynchronous, at any point including mid-stream):
  - State → IDLE, k → 0.
  - `busy`, `out_valid`, `done`, `err` = 0; `out_char` = 0x00.
  - The partial stream is abandoned. After `clr_n` rises, the first `start` is processed normally.
- Latency: `start` accepted at edge 0 → first character valid in cycle 1 (registered, not combinational from `start`).
- With `out_ready` held high: characters appear in cycles 1..2n−1 and `done` in cycle 2n. The next `start` is accepted at the earliest in cycle 2n+1.
- `err` is asserted in cycle 1 for an illegal request; `busy` stays 0.
- `out_ready` may be high before `out_valid`; no transfer occurs without valid.
- Each `out_ready` low cycle adds exactly one cycle to the stream.

## Structure
- Package `expr_pkg`:
  - ASCII constants CH_ZERO = 0x30, CH_PLUS = 0x2B, CH_STAR = 0x2A.
  - Operator encoding OP_ADD = 0, OP_MUL = 1.
  - State encoding typedef IDLE/DIGIT/OP/DONE.
  - These are shared with the checker and future evaluators.
- Sub-module `expr_char_enc`: combinational mapping of (is_op, nibble, op bit) to an ASCII byte. Instantiated once.
- Registered outputs; index counter width $clog2(MAX_TERMS).

## Test plan
- Normal stream:
  - Stimulus: `num_terms` = 3, `digits` = 16'h0172, `ops` = 3'b010, `out_ready` = 1.
  - Response: 0x32, 0x2B, 0x37, 0x2A, 0x31 in cycles 1–5; `done` in cycle 6; `busy` 0 in cycle 7.
- Backpressure:
  - Stimulus: same request, `out_ready` = 0 in cycles 2–4.
  - Response: 0x2B held for cycles 2–5; full sequence emitted with no duplicate or drop; `done` in cycle 9.
- Single term:
  - Stimulus: `num_terms` = 1, term0 = 9.
  - Response: single 0x39 in cycle 1; `done` in cycle 2; no operator emitted.
- Illegal requests:
  - Stimulus: term1 = 0xA with `num_terms` = 2; separately `num_terms` = 0 and `num_terms` = 5.
  - Response: `err` pulse in cycle 1; `out_valid` never asserted; `busy` stays 0.
- Reset mid-stream:
  - Stimulus: drive `clr_n` low during OP.
  - Response: all outputs 0 immediately, without waiting for a clock edge. A following legal `start` restarts from term 0.
- Start while busy:
  - Stimulus: assert `start` with new data in cycle 2.
  - Response: ignored; the original stream completes unchanged.

Source files
------------

// File: rtl/expr_pkg.sv
// Shared definitions for the expression stream: ASCII codes, operator
// encoding and the transmitter state type.
package expr_pkg;

  localparam logic [7:0] CH_ZERO = 8'h30;
  localparam logic [7:0] CH_PLUS = 8'h2B;
  localparam logic [7:0] CH_STAR = 8'h2A;

  localparam logic OP_ADD = 1'b0;
  localparam logic OP_MUL = 1'b1;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    DIGIT = 2'd1,
    OP    = 2'd2,
    DONE  = 2'd3
  } state_t;

  function automatic logic is_bcd(input logic [3:0] nib);
    return (nib <= 4'd9);
  endfunction

endpackage

// File: rtl/expr_char_enc.sv
// Maps one stream element (a BCD digit or an operator bit) to its ASCII byte.
module expr_char_enc
  import expr_pkg::*;
(
  input  logic       is_op_i,
  input  logic [3:0] nibble_i,
  input  logic       op_i,
  output logic [7:0] char_o
);

  // Operator bit selects '*' or '+'; digits are offset from '0'.
  always_comb begin
    if (is_op_i) begin
      char_o = (op_i == OP_MUL) ? CH_STAR : CH_PLUS;
    end else begin
      char_o = CH_ZERO + {4'b0000, nibble_i};
    end
  end

endmodule

// File: rtl/expr_tx.sv
// Serial infix expression transmitter: latches a request of digits and
// operators on start_i and streams "d op d ... d" one byte per handshake.
//
//   state | meaning
//   IDLE  | waiting for start_i; illegal requests pulse err_o
//   DIGIT | presenting term k as an ASCII digit
//   OP    | presenting operator k
//   DONE  | one-cycle done_o pulse, then back to IDLE
//
// All outputs are registered; their next values are decoded from the
// next state so the first character appears the cycle after start_i.
module expr_tx
  import expr_pkg::*;
#(
  parameter int MAX_TERMS = 4
) (
  input  logic                           clk_i,
  input  logic                           clr_n_i,
  input  logic                           start_i,
  input  logic [$clog2(MAX_TERMS+1)-1:0] num_terms_i,
  input  logic [4*MAX_TERMS-1:0]         digits_i,
  input  logic [MAX_TERMS-2:0]           ops_i,
  output logic                           busy_o,
  output logic                           out_valid_o,
  input  logic                           out_ready_i,
  output logic [7:0]                     out_char_o,
  output logic                           done_o,
  output logic                           err_o
);

  localparam int NW = $clog2(MAX_TERMS+1);
  localparam int KW = $clog2(MAX_TERMS);

  state_t                 state_q, state_d;
  logic [KW-1:0]          k_q, k_d;
  logic [NW-1:0]          nterms_q, nterms_d;
  logic [4*MAX_TERMS-1:0] digits_q, digits_d;
  logic [MAX_TERMS-2:0]   ops_q, ops_d;

  logic                   busy_q, busy_d;
  logic                   valid_q, valid_d;
  logic [7:0]             char_q, char_d;
  logic                   done_q, done_d;
  logic                   err_q, err_d;

  logic                   legal;
  logic                   xfer;
  logic [3:0]             enc_nibble;
  logic [MAX_TERMS-1:0]   enc_ops;
  logic                   enc_op;
  logic [7:0]             enc_char;

  assign xfer = valid_q & out_ready_i;

  // Request check: operand count in range and every used term is BCD.
  always_comb begin
    legal = 1'b1;
    if (num_terms_i == '0 || int'(num_terms_i) > MAX_TERMS) begin
      legal = 1'b0;
    end
    for (int i = 0; i < MAX_TERMS; i++) begin
      if (i < int'(num_terms_i) && !is_bcd(digits_i[4*i +: 4])) begin
        legal = 1'b0;
      end
    end
  end

  // Next-state logic; the request is latched only on a legal start in IDLE.
  always_comb begin
    state_d  = state_q;
    k_d      = k_q;
    nterms_d = nterms_q;
    digits_d = digits_q;
    ops_d    = ops_q;
    err_d    = 1'b0;
    case (state_q)
      IDLE: begin
        if (start_i) begin
          if (legal) begin
            state_d  = DIGIT;
            k_d      = '0;
            nterms_d = num_terms_i;
            digits_d = digits_i;
            ops_d    = ops_i;
          end else begin
            err_d = 1'b1;
          end
        end
      end
      DIGIT: begin
        if (xfer) begin
          state_d = (int'(k_q) + 1 < int'(nterms_q)) ? OP : DONE;
        end
      end
      OP: begin
        if (xfer) begin
          k_d     = k_q + KW'(1);
          state_d = DIGIT;
        end
      end
      DONE: begin
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  // Select the element the next state will present. The operator vector is
  // padded so the index stays in range while sitting on the last digit.
  always_comb begin
    enc_ops    = {1'b0, ops_d};
    enc_op     = enc_ops[k_d];
    enc_nibble = digits_d[4*int'(k_d) +: 4];
  end

  expr_char_enc u_enc (
    .is_op_i  (state_d == OP),
    .nibble_i (enc_nibble),
    .op_i     (enc_op),
    .char_o   (enc_char)
  );

  // Output decode from the next state; out_char is forced to 0 when idle.
  always_comb begin
    valid_d = (state_d == DIGIT) || (state_d == OP);
    char_d  = valid_d ? enc_char : 8'h00;
    done_d  = (state_d == DONE);
    busy_d  = (state_d != IDLE);
  end

  // State, latched request and registered outputs.
  always_ff @(posedge clk_i or negedge clr_n_i) begin
    if (!clr_n_i) begin
      state_q  <= IDLE;
      k_q      <= '0;
      nterms_q <= '0;
      digits_q <= '0;
      ops_q    <= '0;
      busy_q   <= 1'b0;
      valid_q  <= 1'b0;
      char_q   <= 8'h00;
      done_q   <= 1'b0;
      err_q    <= 1'b0;
    end else begin
      state_q  <= state_d;
      k_q      <= k_d;
      nterms_q <= nterms_d;
      digits_q <= digits_d;
      ops_q    <= ops_d;
      busy_q   <= busy_d;
      valid_q  <= valid_d;
      char_q   <= char_d;
      done_q   <= done_d;
      err_q    <= err_d;
    end
  end

  assign busy_o      = busy_q;
  assign out_valid_o = valid_q;
  assign out_char_o  = char_q;
  assign done_o      = done_q;
  assign err_o       = err_q;

endmodule
